// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops return a registered result one cycle
// after acceptance; MUL runs on an iterative shift-add datapath behind a
// valid/ready handshake.
module alu_exec_unit #(
  parameter int unsigned MUL_STEP = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [3:0]  ctrl_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [4:0]  shamt_i,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        illegal_o,
  output logic        busy_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned ITERS  = DATA_W / MUL_STEP;
  localparam int unsigned LAST   = ITERS - 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_SLTIU = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_LDST  = 4'b1000;
  localparam logic [3:0] OP_BR    = 4'b1010;
  localparam logic [3:0] OP_LUI   = 4'b1011;
  localparam logic [3:0] OP_SLL   = 4'b1101;
  localparam logic [3:0] OP_SRA   = 4'b1110;
  localparam logic [3:0] OP_SRAV  = 4'b1111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                valid_q, valid_d;
  logic                illegal_q, illegal_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic                accept_c;
  logic [DATA_W-1:0]   alu_c;
  logic                alu_illegal_c;
  logic [DATA_W-1:0]   partial_c;
  logic [DATA_W-1:0]   acc_next_c;

  assign accept_c = valid_i && ready_q;

  // Single-cycle result for the code currently on the inputs
  always_comb begin
    alu_c         = '0;
    alu_illegal_c = 1'b0;
    unique case (ctrl_i)
      OP_AND:   alu_c = src1_i & src2_i;
      OP_OR:    alu_c = src1_i | src2_i;
      OP_ADD:   alu_c = src1_i + src2_i;
      OP_SUB:   alu_c = src1_i - src2_i;
      OP_SLT:   alu_c = {31'd0, ($signed(src1_i) < $signed(src2_i))};
      OP_SLTIU: alu_c = {31'd0, (src1_i < src2_i)};
      OP_SLL:   alu_c = src2_i << shamt_i;
      OP_SRA:   alu_c = DATA_W'($signed(src2_i) >>> shamt_i);
      OP_SRAV:  alu_c = DATA_W'($signed(src2_i) >>> src1_i[4:0]);
      OP_LUI:   alu_c = src2_i << 16;
      OP_BR:    alu_c = src1_i - src2_i;
      OP_LDST:  alu_c = src1_i + src2_i;
      OP_MUL:   alu_c = '0;
      default: begin
        alu_c         = '0;
        alu_illegal_c = 1'b1;
      end
    endcase
  end

  // Partial product for the MUL_STEP low multiplier bits of this iteration
  always_comb begin
    partial_c = '0;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) begin
        partial_c = partial_c + (mcand_q << i);
      end
    end
    acc_next_c = acc_q + partial_c;
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    ready_d   = ready_q;
    busy_d    = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (ctrl_i == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = '0;
            cnt_d    = '0;
            ready_d  = 1'b0;
            busy_d   = 1'b1;
          end else begin
            result_d  = alu_c;
            zero_d    = (alu_c == '0);
            illegal_d = alu_illegal_c;
            valid_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_next_c;
        mcand_d  = mcand_q << MUL_STEP;
        mplier_d = mplier_q >> MUL_STEP;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST)) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          result_d = acc_next_c;
          zero_d   = (acc_next_c == '0);
          valid_d  = 1'b1;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any MUL in flight
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected results,
// monitors pop and compare whenever valid_o is seen.
module tb_alu_exec_unit;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int unsigned cyc;
  } exp_t;

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                         C_MUL = 4'b0100, C_SLTIU = 4'b0101, C_SUB = 4'b0110,
                         C_SLT = 4'b0111, C_LDST = 4'b1000, C_BR = 4'b1010,
                         C_LUI = 4'b1011, C_SLL = 4'b1101, C_SRA = 4'b1110,
                         C_SRAV = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // MUL_STEP=1 instance
  logic        valid_i = 1'b0, ready_o, valid_o, zero_o, illegal_o, busy_o;
  logic [3:0]  ctrl = '0;
  logic [31:0] src1 = '0, src2 = '0, result_o;
  logic [4:0]  shamt = '0;

  // MUL_STEP=4 instance
  logic        v4 = 1'b0, ready4, valid4, zero4, illegal4, busy4;
  logic [3:0]  c4 = '0;
  logic [31:0] a4 = '0, b4 = '0, result4;
  logic [4:0]  sh4 = '0;

  exp_t exp_q[$];
  exp_t exp4_q[$];
  exp_t mon_e, mon4_e;

  alu_exec_unit #(.MUL_STEP(1)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .ctrl_i(ctrl), .src1_i(src1), .src2_i(src2), .shamt_i(shamt),
    .valid_o(valid_o), .result_o(result_o), .zero_o(zero_o),
    .illegal_o(illegal_o), .busy_o(busy_o)
  );

  alu_exec_unit #(.MUL_STEP(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(v4), .ready_o(ready4),
    .ctrl_i(c4), .src1_i(a4), .src2_i(b4), .shamt_i(sh4),
    .valid_o(valid4), .result_o(result4), .zero_o(zero4),
    .illegal_o(illegal4), .busy_o(busy4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present an op at a negedge; returns at the negedge after it is accepted
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] r, input logic ill,
                       input int unsigned lat);
    int guard;
    guard = 0;
    valid_i = 1'b1; ctrl = c; src1 = a; src2 = b; shamt = sh;
    while (!ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_o) begin
      chk("issue_ready", 32'(ready_o), 32'd1);
    end else begin
      exp_q.push_back('{r, (r == 32'd0), ill, cyc + lat});
    end
    @(negedge clk);
  endtask

  task automatic issue4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    int guard;
    guard = 0;
    v4 = 1'b1; c4 = C_MUL; a4 = a; b4 = b;
    while (!ready4 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready4) begin
      chk("issue4_ready", 32'(ready4), 32'd1);
    end else begin
      exp4_q.push_back('{r, (r == 32'd0), 1'b0, cyc + 9});
    end
    @(negedge clk);
    v4 = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Monitor for the MUL_STEP=1 instance
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid: got result %h, expected no result (cycle %0d)", result_o, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", result_o, mon_e.res);
        chk("zero", 32'(zero_o), 32'(mon_e.zero));
        chk("illegal", 32'(illegal_o), 32'(mon_e.ill));
        chk("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
    if (illegal_o && !valid_o) chk("illegal_without_valid", 32'(illegal_o), 32'd0);
  end

  // Monitor for the MUL_STEP=4 instance
  always @(negedge clk) begin
    if (rst_n && valid4) begin
      if (exp4_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid4: got result %h, expected no result (cycle %0d)", result4, cyc);
      end else begin
        mon4_e = exp4_q.pop_front();
        chk("result4", result4, mon4_e.res);
        chk("zero4", 32'(zero4), 32'(mon4_e.zero));
        chk("latency4_cycle", 32'(cyc), 32'(mon4_e.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_zero", 32'(zero_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(ready_o), 32'd1);

    // Back-to-back single-cycle ops, valid held four cycles
    issue(C_ADD,   32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 1);
    issue(C_SUB,   32'd5,         32'd5, 5'd0, 32'd0,         1'b0, 1);
    issue(C_SLT,   32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1,         1'b0, 1);
    issue(C_SLTIU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0,         1'b0, 1);
    idle(2);

    // Shifts, logic, address
    issue(C_SRA,  32'd0,       32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1);
    issue(C_SRAV, 32'h24,      32'h8000_0000, 5'd0,  32'hF800_0000, 1'b0, 1);
    issue(C_SLL,  32'd0,       32'd1,         5'd31, 32'h8000_0000, 1'b0, 1);
    issue(C_SLL,  32'd0,       32'hA5,        5'd0,  32'hA5,        1'b0, 1);
    issue(C_AND,  32'hF0F0,    32'hFF00,      5'd0,  32'hF000,      1'b0, 1);
    issue(C_OR,   32'hF0F0,    32'hFF00,      5'd0,  32'hFFF0,      1'b0, 1);
    issue(C_LDST, 32'h1000,    32'h24,        5'd0,  32'h1024,      1'b0, 1);
    issue(C_LUI,  32'd0,       32'h1234,      5'd0,  32'h1234_0000, 1'b0, 1);
    idle(2);

    // Asynchronous reset mid-cycle, result_o currently nonzero
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_result", result_o, 32'd0);
    chk("async_rst_zero", 32'(zero_o), 32'd1);
    chk("async_rst_ready", 32'(ready_o), 32'd1);
    chk("async_rst_illegal", 32'(illegal_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Illegal codes and BRANCH equality
    issue(4'b0011, 32'd3, 32'd4, 5'd0, 32'd0, 1'b1, 1);
    issue(4'b1001, 32'd3, 32'd4, 5'd0, 32'd0, 1'b1, 1);
    issue(4'b1100, 32'd3, 32'd4, 5'd0, 32'd0, 1'b1, 1);
    issue(C_BR,    32'd9, 32'd9, 5'd0, 32'd0, 1'b0, 1);
    issue(C_BR,    32'd9, 32'd8, 5'd0, 32'd1, 1'b0, 1);
    idle(2);

    // MUL with toggling valid_i during busy; it must be ignored
    issue(C_MUL, 32'hFFFF_FFFF, 32'd3, 5'd0, 32'hFFFF_FFFD, 1'b0, 33);
    cnt = 0;
    ctrl = C_ADD; src1 = 32'd1; src2 = 32'd1;
    for (int k = 0; k < 100; k++) begin
      if (!(busy_o && !ready_o)) break;
      cnt++;
      valid_i = (k < 20) ? k[0] : 1'b0;
      @(negedge clk);
    end
    valid_i = 1'b0;
    chk("mul_busy_cycles", 32'(cnt), 32'd32);
    idle(3);

    // MUL aborted by reset at iteration 10
    issue(C_MUL, 32'd7, 32'd6, 5'd0, 32'd42, 1'b0, 33);
    valid_i = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_ready", 32'(ready_o), 32'd1);

    // Reissue MUL, plus the MUL_STEP=4 instance in parallel
    fork
      issue(C_MUL, 32'd7, 32'd6, 5'd0, 32'd42, 1'b0, 33);
      issue4(32'd7, 32'd6, 32'd42);
    join
    valid_i = 1'b0;
    repeat (12) @(negedge clk);
    issue4(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);

    // Drain both scoreboards with a bound
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && exp4_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_q", 32'(exp_q.size()), 32'd0);
    chk("drain_q4", 32'(exp4_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
